// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// for a shared-memory, single-ALU datapath and traps unsupported opcodes.
module mc_ctrl_fsm #(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter bit ILLEGAL_TRAP  = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic [1:0] pc_source,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_RESET  = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MADDR  = 4'd3,
    S_MRD    = 4'd4,
    S_MWB    = 4'd5,
    S_MWR    = 4'd6,
    S_REXE   = 4'd7,
    S_RWB    = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_IEXE   = 4'd11,
    S_IWB    = 4'd12,
    S_TRAP   = 4'd13
  } state_t;

  localparam logic [5:0] OP_R    = 6'd0;
  localparam logic [5:0] OP_J    = 6'd2;
  localparam logic [5:0] OP_BEQ  = 6'd4;
  localparam logic [5:0] OP_ADDI = 6'd8;
  localparam logic [5:0] OP_ORI  = 6'd13;
  localparam logic [5:0] OP_LW   = 6'd35;
  localparam logic [5:0] OP_SW   = 6'd43;

  state_t     state_r;
  logic [5:0] op_r;
  logic       illegal_r;
  logic       rdy_s;

  assign rdy_s = MEM_HANDSHAKE ? mem_ready : 1'b1;

  // State sequencing, opcode capture and the registered illegal-opcode flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= S_RESET;
      op_r      <= 6'd0;
      illegal_r <= 1'b0;
    end else begin
      illegal_r <= 1'b0;
      case (state_r)
        S_RESET:  state_r <= S_FETCH;
        S_FETCH:  state_r <= rdy_s ? S_DECODE : S_FETCH;
        S_DECODE: begin
          op_r <= opcode;
          case (opcode)
            OP_LW, OP_SW:     state_r <= S_MADDR;
            OP_R:             state_r <= S_REXE;
            OP_BEQ:           state_r <= S_BRANCH;
            OP_J:             state_r <= S_JUMP;
            OP_ADDI, OP_ORI:  state_r <= S_IEXE;
            default: begin
              illegal_r <= 1'b1;
              state_r   <= ILLEGAL_TRAP ? S_TRAP : S_FETCH;
            end
          endcase
        end
        S_MADDR:  state_r <= (op_r == OP_LW) ? S_MRD : S_MWR;
        S_MRD:    state_r <= rdy_s ? S_MWB : S_MRD;
        S_MWB:    state_r <= S_FETCH;
        S_MWR:    state_r <= rdy_s ? S_FETCH : S_MWR;
        S_REXE:   state_r <= S_RWB;
        S_RWB:    state_r <= S_FETCH;
        S_BRANCH: state_r <= S_FETCH;
        S_JUMP:   state_r <= S_FETCH;
        S_IEXE:   state_r <= S_IWB;
        S_IWB:    state_r <= S_FETCH;
        S_TRAP: begin
          illegal_r <= 1'b1;
          state_r   <= S_TRAP;
        end
        default:  state_r <= S_RESET;
      endcase
    end
  end

  // Datapath controls decoded from the state; only FETCH and MWR look at mem_ready
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 3'b000;
    pc_source     = 2'b00;
    instr_done    = 1'b0;
    case (state_r)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        alu_op    = 3'b010;
        ir_write  = rdy_s;
        pc_write  = rdy_s;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        alu_op    = 3'b010;
      end
      S_MADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = 3'b010;
      end
      S_MRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      S_MWR: begin
        mem_write  = 1'b1;
        iord       = 1'b1;
        instr_done = rdy_s;
      end
      S_REXE: begin
        alu_src_a = 1'b1;
        alu_op    = 3'b100;
      end
      S_RWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 3'b110;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        instr_done    = 1'b1;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        instr_done = 1'b1;
      end
      S_IEXE: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = (op_r == OP_ORI) ? 3'b001 : 3'b010;
      end
      S_IWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      default: begin
        pc_write = 1'b0;
      end
    endcase
  end

  assign illegal_op = illegal_r;
  assign state      = state_r;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench: two FSM instances (trap / no-trap) run directed and random
// instruction streams against an instruction-level reference model.
module tb_mc_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic [1:0][22:0] obs;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done, illegal_op;
    logic [1:0] alu_src_b, pc_source;
    logic [2:0] alu_op;
    logic [3:0] state;
    mc_ctrl_fsm #(.MEM_HANDSHAKE(1'b1), .ILLEGAL_TRAP(g == 0)) u_dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
      .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .pc_source(pc_source), .instr_done(instr_done), .illegal_op(illegal_op),
      .state(state)
    );
    assign obs[g] = {state, pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                     mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                     pc_source, instr_done, illegal_op};
  end

  localparam logic [22:0] TRAP_VEC = {4'd13, 18'd0, 1'b1};

  int total = 0;
  int bad   = 0;

  // Model: opcode of current instruction and step within it (0 = fetch, 1 = decode, ...)
  logic [5:0] m_op;
  int         m_k;
  logic       a_trap;
  logic       b_pulse;
  logic [5:0] legal_ops [7] = '{6'd0, 6'd2, 6'd4, 6'd8, 6'd13, 6'd35, 6'd43};

  function automatic logic is_legal(input logic [5:0] op);
    return op == 6'd0 || op == 6'd2 || op == 6'd4 || op == 6'd8 ||
           op == 6'd13 || op == 6'd35 || op == 6'd43;
  endfunction

  // Expected control bundle for step k of instruction op (illegal_op bit left 0)
  function automatic logic [22:0] exp_vec(input logic [5:0] op, input int k, input logic rdy);
    logic [3:0] st;
    logic pcw, pwc, io, mr, mw, irw, m2r, rd, rw, sa, dn;
    logic [1:0] sb, ps;
    logic [2:0] ao;
    st = 4'd0; pcw = 1'b0; pwc = 1'b0; io = 1'b0; mr = 1'b0; mw = 1'b0; irw = 1'b0;
    m2r = 1'b0; rd = 1'b0; rw = 1'b0; sa = 1'b0; dn = 1'b0;
    sb = 2'b00; ps = 2'b00; ao = 3'b000;
    if (k == 0) begin
      st = 4'd1; mr = 1'b1; sb = 2'b01; ao = 3'b010; irw = rdy; pcw = rdy;
    end else if (k == 1) begin
      st = 4'd2; sb = 2'b11; ao = 3'b010;
    end else if (k == 2) begin
      if (op == 6'd35 || op == 6'd43) begin st = 4'd3; sa = 1'b1; sb = 2'b10; ao = 3'b010; end
      else if (op == 6'd0) begin st = 4'd7; sa = 1'b1; ao = 3'b100; end
      else if (op == 6'd4) begin st = 4'd9; sa = 1'b1; ao = 3'b110; pwc = 1'b1; ps = 2'b01; dn = 1'b1; end
      else if (op == 6'd2) begin st = 4'd10; pcw = 1'b1; ps = 2'b10; dn = 1'b1; end
      else begin st = 4'd11; sa = 1'b1; sb = 2'b10; ao = (op == 6'd13) ? 3'b001 : 3'b010; end
    end else if (k == 3) begin
      if (op == 6'd35) begin st = 4'd4; mr = 1'b1; io = 1'b1; end
      else if (op == 6'd43) begin st = 4'd6; mw = 1'b1; io = 1'b1; dn = rdy; end
      else if (op == 6'd0) begin st = 4'd8; rw = 1'b1; rd = 1'b1; dn = 1'b1; end
      else begin st = 4'd12; rw = 1'b1; dn = 1'b1; end
    end else begin
      st = 4'd5; rw = 1'b1; m2r = 1'b1; dn = 1'b1;
    end
    return {st, pcw, pwc, io, mr, mw, irw, m2r, rd, rw, sa, sb, ao, ps, dn, 1'b0};
  endfunction

  task automatic chk(input string tag, input int g, input logic [22:0] o, input logic [22:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s dut%0d: observed=%h expected=%h", tag, g, o, e);
    end
  endtask

  task automatic advance(input logic rdy);
    b_pulse = 1'b0;
    case (m_k)
      0: if (rdy) m_k = 1;
      1: if (!is_legal(m_op)) begin m_k = 0; a_trap = 1'b1; b_pulse = 1'b1; end
         else m_k = 2;
      2: m_k = (m_op == 6'd4 || m_op == 6'd2) ? 0 : 3;
      3: if (m_op == 6'd35) m_k = rdy ? 4 : 3;
         else if (m_op == 6'd43) m_k = rdy ? 0 : 3;
         else m_k = 0;
      default: m_k = 0;
    endcase
  endtask

  // Entered just after a rising edge; checks this cycle, then steps the model
  task automatic step_cycle(input logic rdy);
    logic [22:0] e;
    string tag;
    mem_ready = rdy;
    opcode = (m_k == 1) ? m_op : 6'($urandom_range(0, 63));
    #1;
    e = exp_vec(m_op, m_k, rdy);
    tag = $sformatf("op%0d_k%0d_rdy%0d", m_op, m_k, rdy);
    chk(tag, 0, obs[0], a_trap ? TRAP_VEC : e);
    chk(tag, 1, obs[1], e | {22'd0, b_pulse});
    @(posedge clk); #1;
    advance(rdy);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; #1;
    chk("rst_low", 0, obs[0], 23'd0);
    chk("rst_low", 1, obs[1], 23'd0);
    @(posedge clk); #1;
    chk("rst_hold", 0, obs[0], 23'd0);
    rst_n = 1'b1; #1;
    chk("rst_rel", 0, obs[0], 23'd0);
    chk("rst_rel", 1, obs[1], 23'd0);
    @(posedge clk); #1;
    m_k = 0; a_trap = 1'b0; b_pulse = 1'b0;
  endtask

  // stalls < 0: random mem_ready every cycle; else that many stalls in the data-memory step
  task automatic run_instr(input logic [5:0] op, input int stalls);
    int n = 0;
    int left = stalls;
    logic rdy;
    m_op = op;
    do begin
      if (stalls < 0) rdy = ($urandom_range(0, 3) != 0);
      else if (m_k == 3 && left > 0) begin rdy = 1'b0; left--; end
      else rdy = 1'b1;
      step_cycle(rdy);
      n++;
    end while (m_k == 0 && n < 100);
    while (m_k != 0 && n < 200) begin
      if (stalls < 0) rdy = ($urandom_range(0, 3) != 0);
      else if (m_k == 3 && left > 0) begin rdy = 1'b0; left--; end
      else rdy = 1'b1;
      step_cycle(rdy);
      n++;
    end
    if (n >= 200 || (n >= 100 && m_k == 0 && is_legal(op) && stalls < 0 && n < 101)) begin
      total++; bad++;
      $error("FAIL timeout op%0d: cycles=%0d limit=200", op, n);
    end
  endtask

  initial begin
    rst_n = 1'b1; mem_ready = 1'b1; opcode = 6'd0;
    m_op = 6'd0; m_k = 0; a_trap = 1'b0; b_pulse = 1'b0;
    #2;
    do_reset();
    run_instr(6'd35, 0);
    run_instr(6'd35, 3);
    run_instr(6'd0, 0);
    run_instr(6'd4, 0);
    run_instr(6'd2, 0);
    run_instr(6'd13, 0);
    run_instr(6'd8, 0);
    run_instr(6'd43, 2);
    for (int i = 0; i < 120; i++) run_instr(legal_ops[$urandom_range(0, 6)], -1);
    // illegal opcode: instance 0 parks in TRAP while instance 1 keeps executing
    run_instr(6'd63, 0);
    for (int i = 0; i < 25; i++) run_instr(legal_ops[$urandom_range(0, 6)], -1);
    do_reset();
    for (int i = 0; i < 3; i++) run_instr(legal_ops[$urandom_range(0, 6)], -1);
    // reset asserted while a store is stalled in MWR
    m_op = 6'd43;
    for (int i = 0; i < 3; i++) step_cycle(1'b1);
    mem_ready = 1'b0; opcode = 6'($urandom_range(0, 63)); #1;
    chk("mwr_stall", 0, obs[0], exp_vec(6'd43, 3, 1'b0));
    chk("mwr_stall", 1, obs[1], exp_vec(6'd43, 3, 1'b0));
    do_reset();
    run_instr(6'd35, 0);
    run_instr(6'd63, 1);
    for (int i = 0; i < 5; i++) run_instr(legal_ops[$urandom_range(0, 6)], -1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
